// File: rtl/coin_session_ctrl.sv
// Coin/credit session controller feeding the countdown timer stage.
// Ports: Clk, Reset (sync, active-high); CoinIn (async level), ModeBtn,
//   StartBtn (1-cycle pulses), TimeUp (from timer); CounterInput[3:0],
//   CounterEnable, CounterLoad, Credit[3:0], Busy, Done, Reject, CoinReturn.
module coin_session_ctrl #(
  parameter int MAX_CREDIT  = 9,
  parameter int COST_SHORT  = 1,
  parameter int COST_LONG   = 2,
  parameter int DONE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       CoinIn,
  input  logic       ModeBtn,
  input  logic       StartBtn,
  input  logic       TimeUp,
  output logic [3:0] CounterInput,
  output logic       CounterEnable,
  output logic       CounterLoad,
  output logic [3:0] Credit,
  output logic       Busy,
  output logic       Done,
  output logic       Reject,
  output logic       CoinReturn
);

  localparam logic [3:0] MAXC   = 4'(MAX_CREDIT);
  localparam logic [3:0] COST_S = 4'(COST_SHORT);
  localparam logic [3:0] COST_L = 4'(COST_LONG);
  localparam logic [3:0] M_SHORT = 4'd1;
  localparam logic [3:0] M_LONG  = 4'd9;

  // Counter holds DONE_CYCLES-1 down to 0, giving DONE_CYCLES cycles.
  localparam int CW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DONE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_EXP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      mode_q, mode_d;
  logic [3:0]      credit_q, credit_d;
  logic            reject_q, reject_d;
  logic            cret_q, cret_d;
  logic            s1_q, s2_q, s3_q;

  logic            coin_ev;
  logic            paid;
  logic [3:0]      cost;
  logic [3:0]      base;

  assign coin_ev = s2_q & ~s3_q;
  assign cost    = (mode_q == M_LONG) ? COST_L : COST_S;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mode_q   <= M_SHORT;
      credit_q <= '0;
      reject_q <= 1'b0;
      cret_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
      cret_q   <= cret_d;
      s1_q     <= CoinIn;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    cret_d   = 1'b0;
    paid     = 1'b0;
    base     = credit_q;

    unique case (state_q)
      S_IDLE: begin
        // Start wins over a same-cycle mode toggle.
        if (StartBtn) begin
          if (credit_q >= cost) begin
            paid    = 1'b1;
            state_d = S_LOAD;
          end else begin
            reject_d = 1'b1;
          end
        end else if (ModeBtn) begin
          mode_d = (mode_q == M_SHORT) ? M_LONG : M_SHORT;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (TimeUp) begin
          state_d = S_EXP;
          cnt_d   = CNT_INIT;
        end
      end
      S_EXP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Charge first (affordability used pre-coin credit), then add coin.
    if (paid) begin
      base = credit_q - cost;
    end
    credit_d = base;
    if (coin_ev) begin
      if (base < MAXC) begin
        credit_d = base + 4'd1;
      end else begin
        cret_d = 1'b1;
      end
    end
  end

  assign CounterInput  = mode_q;
  assign CounterEnable = (state_q == S_RUN);
  assign CounterLoad   = (state_q == S_LOAD);
  assign Busy          = (state_q != S_IDLE);
  assign Done          = (state_q == S_EXP);
  assign Credit        = credit_q;
  assign Reject        = reject_q;
  assign CoinReturn    = cret_q;

endmodule

// File: tb/tb_coin_session_ctrl.sv
// Directed self-checking bench for coin_session_ctrl.
// Drives inputs 1ns after the rising edge; checks at the same point.
module tb_coin_session_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin = 1'b0;
  logic       mode_b = 1'b0;
  logic       start_b = 1'b0;
  logic       tup = 1'b0;
  logic [3:0] cin;
  logic       cen, cload, busy, done, rej, cret;
  logic [3:0] credit;

  int errors = 0;
  int checks = 0;
  int en_n = 0, load_n = 0, done_n = 0, rej_n = 0, cret_n = 0;
  int b_en, b_load, b_done, b_rej, b_cret;

  coin_session_ctrl dut (
    .Clk(clk),
    .Reset(rst),
    .CoinIn(coin),
    .ModeBtn(mode_b),
    .StartBtn(start_b),
    .TimeUp(tup),
    .CounterInput(cin),
    .CounterEnable(cen),
    .CounterLoad(cload),
    .Credit(credit),
    .Busy(busy),
    .Done(done),
    .Reject(rej),
    .CoinReturn(cret)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cen)   en_n   <= en_n + 1;
    if (cload) load_n <= load_n + 1;
    if (done)  done_n <= done_n + 1;
    if (rej)   rej_n  <= rej_n + 1;
    if (cret)  cret_n <= cret_n + 1;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clean coin; credit is updated when this returns.
  task automatic put_coin();
    coin = 1'b1;
    step(2);
    coin = 1'b0;
    step(3);
  endtask

  task automatic snap();
    b_en = en_n; b_load = load_n; b_done = done_n;
    b_rej = rej_n; b_cret = cret_n;
  endtask

  initial begin
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_cin", cin, 1);
    chk("rst_credit", credit, 0);
    chk("rst_en", cen, 0);
    chk("rst_load", cload, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rej", rej, 0);
    chk("rst_cret", cret, 0);

    // Short session
    put_coin();
    chk("short_credit1", credit, 1);
    snap();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("short_load", cload, 1);
    chk("short_credit0", credit, 0);
    chk("short_busy", busy, 1);
    chk("short_en_in_load", cen, 0);
    step();
    chk("short_run_en", cen, 1);
    chk("short_run_load", cload, 0);
    step(19);
    tup = 1'b1;
    step();
    tup = 1'b0;
    chk("short_exp_done", done, 1);
    chk("short_exp_en", cen, 0);
    step(3);
    chk("short_done_hold", done, 1);
    step();
    chk("short_idle_done", done, 0);
    chk("short_idle_busy", busy, 0);
    chk("short_en_cycles", en_n - b_en, 20);
    chk("short_load_cycles", load_n - b_load, 1);
    chk("short_done_cycles", done_n - b_done, 4);

    // Long session, first refused
    put_coin();
    mode_b = 1'b1;
    step();
    mode_b = 1'b0;
    chk("long_mode", cin, 9);
    snap();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("long_reject", rej, 1);
    chk("long_rej_credit", credit, 1);
    chk("long_rej_busy", busy, 0);
    step();
    chk("long_rej_width", rej_n - b_rej, 1);
    put_coin();
    chk("long_credit2", credit, 2);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("long_load", cload, 1);
    chk("long_credit0", credit, 0);
    chk("long_cin_load", cin, 9);
    step();
    chk("long_run_en", cen, 1);
    chk("long_cin_run", cin, 9);

    // Ignored inputs in RUN
    snap();
    mode_b = 1'b1;
    start_b = 1'b1;
    step();
    mode_b = 1'b0;
    start_b = 1'b0;
    chk("run_mode_ign", cin, 9);
    chk("run_en_kept", cen, 1);
    put_coin();
    chk("run_coin_credit", credit, 1);
    chk("run_coin_en", cen, 1);
    chk("run_no_reject", rej_n - b_rej, 0);

    // Reset mid-RUN
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_credit", credit, 0);
    chk("mid_rst_cin", cin, 1);
    chk("mid_rst_en", cen, 0);
    step();
    chk("mid_rst_stay", busy, 0);

    // Saturation
    snap();
    repeat (11) put_coin();
    chk("sat_credit", credit, 9);
    chk("sat_returns", cret_n - b_cret, 2);

    // Coin and start in the same cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    put_coin();
    chk("sim_pre_credit", credit, 1);
    coin = 1'b1;
    step(2);
    coin = 1'b0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("sim_load", cload, 1);
    chk("sim_credit", credit, 1);
    step();
    tup = 1'b1;
    step();
    tup = 1'b0;
    step(4);
    chk("sim_idle", busy, 0);

    // Mode and start together: old mode used, toggle dropped
    mode_b = 1'b1;
    start_b = 1'b1;
    step();
    mode_b = 1'b0;
    start_b = 1'b0;
    chk("ms_load", cload, 1);
    chk("ms_cin", cin, 1);
    chk("ms_credit", credit, 0);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
